// File: rtl/crc_slave.sv
// crc_slave: memory-mapped slave around a bit-serial CRC generator.
// The host writes a message word, starts a computation, polls the status
// register, then reads back the codeword {message, CRC remainder}.
// The engine processes one augmented message bit per clock.
//
// Ports:
//   clk             in   1           single rising-edge clock
//   reset           in   1           synchronous, active-high
//   addr            in   2           register select
//   cs              in   1           chip select, qualifies read/write
//   write           in   1           write strobe
//   read            in   1           read strobe
//   write_data      in   DATA_WIDTH  write data
//   read_data       out  DATA_WIDTH  registered read data
//   read_data_valid out  1           one-cycle pulse after an accepted read
//   wait_req        out  1           engine busy; writes are ignored
//
// Register map:
//   addr0  W: DATA             R: DATA
//   addr1  W: DATA and start   R: RESULT
//   addr2  W: ignored          R: {0.., done, busy}
//   addr3  W: ignored          R: RESULT[CRC_WIDTH-1:0] zero-extended
module crc_slave #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          CRC_WIDTH  = 3,
    parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = 3'h3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic                  cs,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_data_valid,
    output logic                  wait_req
);

    localparam int unsigned COUNTER_WIDTH  = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned LSB_DATA_WIDTH = DATA_WIDTH - CRC_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] LAST_BIT = COUNTER_WIDTH'(DATA_WIDTH - 1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_START  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CRC    = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // State and datapath registers
    state_t                   r_state;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [DATA_WIDTH-1:0]    r_result;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic [CRC_WIDTH-1:0]     r_rem;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_done;
    logic                     r_wait_req;
    logic [DATA_WIDTH-1:0]    r_read_data;
    logic                     r_read_data_valid;

    // Next-state values
    state_t                   w_state_nxt;
    logic [DATA_WIDTH-1:0]    w_data_nxt;
    logic [DATA_WIDTH-1:0]    w_result_nxt;
    logic [DATA_WIDTH-1:0]    w_shift_nxt;
    logic [CRC_WIDTH-1:0]     w_rem_nxt;
    logic [COUNTER_WIDTH-1:0] w_count_nxt;
    logic                     w_done_nxt;
    logic                     w_wait_req_nxt;
    logic [DATA_WIDTH-1:0]    w_read_data_nxt;
    logic                     w_read_data_valid_nxt;

    // Bus decode and one step of the remainder update
    logic                     w_write_ok;
    logic                     w_read_ok;
    logic                     w_load;
    logic                     w_start;
    logic                     w_busy;
    logic                     w_fb;
    logic [CRC_WIDTH-1:0]     w_rem_step;
    logic [DATA_WIDTH-1:0]    w_status;

    assign w_write_ok = cs & write & ~r_wait_req;
    assign w_read_ok  = cs & read;
    assign w_load     = w_write_ok & ((addr == ADDR_DATA) | (addr == ADDR_START));
    assign w_start    = w_write_ok & (addr == ADDR_START) & (r_state == IDLE);
    assign w_busy     = (r_state == SHIFT);
    assign w_status   = {{(DATA_WIDTH-2){1'b0}}, r_done, w_busy};

    // Remainder shifts in the next augmented bit; feedback folds in the generator
    assign w_fb       = r_rem[CRC_WIDTH-1];
    assign w_rem_step = {r_rem[CRC_WIDTH-2:0], r_shift[DATA_WIDTH-1]}
                        ^ (w_fb ? POLYNOMIAL : {CRC_WIDTH{1'b0}});

    // Next-state and datapath logic
    always_comb begin
        w_state_nxt           = r_state;
        w_data_nxt            = r_data;
        w_result_nxt          = r_result;
        w_shift_nxt           = r_shift;
        w_rem_nxt             = r_rem;
        w_count_nxt           = r_count;
        w_done_nxt            = r_done;
        w_wait_req_nxt        = r_wait_req;
        w_read_data_nxt       = r_read_data;
        w_read_data_valid_nxt = w_read_ok;

        if (w_load) begin
            w_data_nxt = write_data;
        end

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt    = SHIFT;
                    w_done_nxt     = 1'b0;
                    w_shift_nxt    = {write_data[LSB_DATA_WIDTH-1:0], {CRC_WIDTH{1'b0}}};
                    w_rem_nxt      = {CRC_WIDTH{1'b0}};
                    w_count_nxt    = {COUNTER_WIDTH{1'b0}};
                    w_wait_req_nxt = 1'b1;
                end
            end
            SHIFT: begin
                w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b0};
                w_rem_nxt   = w_rem_step;
                w_count_nxt = r_count + COUNTER_WIDTH'(1);
                if (r_count == LAST_BIT) begin
                    // DATA cannot change while busy, so it still holds the message
                    w_state_nxt    = IDLE;
                    w_result_nxt   = {r_data[LSB_DATA_WIDTH-1:0], w_rem_step};
                    w_done_nxt     = 1'b1;
                    w_wait_req_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Reads sample the pre-write register contents
        if (w_read_ok) begin
            case (addr)
                ADDR_DATA:   w_read_data_nxt = r_data;
                ADDR_START:  w_read_data_nxt = r_result;
                ADDR_STATUS: w_read_data_nxt = w_status;
                ADDR_CRC:    w_read_data_nxt = DATA_WIDTH'(r_result[CRC_WIDTH-1:0]);
                default:     w_read_data_nxt = {DATA_WIDTH{1'b0}};
            endcase
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= IDLE;
            r_data            <= {DATA_WIDTH{1'b0}};
            r_result          <= {DATA_WIDTH{1'b0}};
            r_shift           <= {DATA_WIDTH{1'b0}};
            r_rem             <= {CRC_WIDTH{1'b0}};
            r_count           <= {COUNTER_WIDTH{1'b0}};
            r_done            <= 1'b0;
            r_wait_req        <= 1'b0;
            r_read_data       <= {DATA_WIDTH{1'b0}};
            r_read_data_valid <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_data            <= w_data_nxt;
            r_result          <= w_result_nxt;
            r_shift           <= w_shift_nxt;
            r_rem             <= w_rem_nxt;
            r_count           <= w_count_nxt;
            r_done            <= w_done_nxt;
            r_wait_req        <= w_wait_req_nxt;
            r_read_data       <= w_read_data_nxt;
            r_read_data_valid <= w_read_data_valid_nxt;
        end
    end

    assign read_data       = r_read_data;
    assign read_data_valid = r_read_data_valid;
    assign wait_req        = r_wait_req;

endmodule

// File: tb/tb_crc_slave.sv
// Testbench for crc_slave: directed register-map steps plus random messages
// checked against a polynomial long-division reference model.
module tb_crc_slave;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        cs;
    logic        write;
    logic        read;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        wait_req;

    int unsigned n_tests;
    int unsigned n_fail;

    crc_slave dut (
        .clk             (clk),
        .reset           (reset),
        .addr            (addr),
        .cs              (cs),
        .write           (write),
        .read            (read),
        .write_data      (write_data),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .wait_req        (wait_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Codeword = {message[28:0], (message * x^3) mod (x^3 + x + 1)}
    function automatic logic [31:0] ref_codeword(input logic [31:0] msg);
        logic [63:0] m;
        logic [28:0] body;
        body = msg[28:0];
        m    = 64'(body) << 3;
        for (int i = 31; i >= 3; i--) begin
            if (m[i]) m = m ^ (64'hB << (i - 3));
        end
        return {body, m[2:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and outputs settle #1 after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cs = 1'b0; write = 1'b0; read = 1'b0; addr = 2'd0; write_data = 32'h0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; write_data = d;
        tick();
        bus_idle();
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
        tick();
        bus_idle();
        d = read_data;
    endtask

    // Counts busy cycles; a runaway engine is reported as a failure
    task automatic wait_idle(output int n);
        n = 0;
        while (wait_req === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        if (n >= 200) check("busy_timeout", 32'(wait_req), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] msg;
        logic [31:0] other;
        logic [31:0] exp_cw;
        int          nb;

        n_tests = 0;
        n_fail  = 0;
        bus_idle();

        // Reset values
        reset = 1'b1;
        tick(); tick();
        check("rst_read_data", read_data, 32'h0);
        check("rst_valid", 32'(read_data_valid), 32'h0);
        check("rst_wait_req", 32'(wait_req), 32'h0);
        reset = 1'b0;
        do_read(2'd2, rd);
        check("rst_status", rd, 32'h0);

        // Reference message from the datasheet example
        do_write(2'd0, 32'h0089CADE);
        do_read(2'd0, rd);
        check("data_reg", rd, 32'h0089CADE);
        do_write(2'd1, 32'h0089CADE);
        check("wait_req_rises", 32'(wait_req), 32'h1);
        wait_idle(nb);
        check("busy_cycles", 32'(nb), 32'd32);
        do_read(2'd1, rd);
        check("ex_result", rd, 32'h044E56F3);
        check("ex_model", rd, ref_codeword(32'h0089CADE));
        do_read(2'd3, rd);
        check("ex_crc", rd, 32'h3);
        do_read(2'd2, rd);
        check("ex_status", rd, 32'h2);

        // Single set bit and all-zero message
        do_write(2'd1, 32'h00000001);
        wait_idle(nb);
        do_read(2'd1, rd);
        check("one_result", rd, ref_codeword(32'h1));
        do_write(2'd1, 32'h00000000);
        do_read(2'd2, rd);
        check("status_busy", rd, 32'h1);
        wait_idle(nb);
        do_read(2'd1, rd);
        check("zero_result", rd, 32'h0);
        do_read(2'd2, rd);
        check("zero_done", rd, 32'h2);

        // Upper message bits are dropped from the codeword
        do_write(2'd1, 32'hFFFFFFFF);
        wait_idle(nb);
        do_read(2'd1, rd);
        check("top_bits_result", rd, ref_codeword(32'hFFFFFFFF));
        do_read(2'd0, rd);
        check("top_bits_data", rd, 32'hFFFFFFFF);

        // Writes while busy are ignored
        msg   = $urandom;
        other = ~msg;
        do_write(2'd1, msg);
        tick(); tick();
        do_write(2'd0, other);
        do_write(2'd1, other);
        wait_idle(nb);
        check("busy_write_len", 32'(nb), 32'd28);
        do_read(2'd0, rd);
        check("busy_write_data", rd, msg);
        do_read(2'd1, rd);
        check("busy_write_result", rd, ref_codeword(msg));

        // Same-cycle read and write returns the old value
        cs = 1'b1; read = 1'b1; write = 1'b1; addr = 2'd0; write_data = 32'hA5A5A5A5;
        tick();
        bus_idle();
        check("rw_old_value", read_data, msg);
        do_read(2'd0, rd);
        check("rw_new_value", rd, 32'hA5A5A5A5);

        // Chip select gates both strobes
        cs = 1'b0; write = 1'b1; read = 1'b1; addr = 2'd1; write_data = 32'h12345678;
        tick();
        check("cs0_no_start", 32'(wait_req), 32'h0);
        check("cs0_no_valid", 32'(read_data_valid), 32'h0);
        bus_idle();
        cs = 1'b1; read = 1'b1; addr = 2'd1;
        tick();
        bus_idle();
        check("valid_pulse_hi", 32'(read_data_valid), 32'h1);
        tick();
        check("valid_pulse_lo", 32'(read_data_valid), 32'h0);

        // Start held continuously restarts on the first idle cycle
        cs = 1'b1; write = 1'b1; addr = 2'd1; write_data = 32'h0000BEEF;
        tick();
        wait_idle(nb);
        check("held_busy_cycles", 32'(nb), 32'd32);
        tick();
        check("held_restart", 32'(wait_req), 32'h1);
        bus_idle();
        wait_idle(nb);
        do_read(2'd1, rd);
        check("held_result", rd, ref_codeword(32'h0000BEEF));

        // Reset in the middle of a computation
        do_write(2'd1, 32'h13579BDF);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_wait_req", 32'(wait_req), 32'h0);
        do_read(2'd1, rd);
        check("midrst_result", rd, 32'h0);
        do_read(2'd2, rd);
        check("midrst_status", rd, 32'h0);

        // Random messages against the reference model
        for (int k = 0; k < 8; k++) begin
            msg    = $urandom;
            exp_cw = ref_codeword(msg);
            do_write(2'd1, msg);
            wait_idle(nb);
            check("rnd_busy_cycles", 32'(nb), 32'd32);
            do_read(2'd1, rd);
            check("rnd_result", rd, exp_cw);
            do_read(2'd3, rd);
            check("rnd_crc", rd, {29'h0, exp_cw[2:0]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
